// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALUop codes, MDU state type and helpers.
package ex_pkg;

  localparam logic [4:0] ALUOP_ADD   = 5'b01101;
  localparam logic [4:0] ALUOP_SUB   = 5'b01110;
  localparam logic [4:0] ALUOP_AND   = 5'b00111;
  localparam logic [4:0] ALUOP_OR    = 5'b00110;
  localparam logic [4:0] ALUOP_XOR   = 5'b00101;
  localparam logic [4:0] ALUOP_SLL   = 5'b01000;
  localparam logic [4:0] ALUOP_SRL   = 5'b01001;
  localparam logic [4:0] ALUOP_MUL   = 5'b11000;
  localparam logic [4:0] ALUOP_MULHU = 5'b11001;
  localparam logic [4:0] ALUOP_DIVU  = 5'b11010;
  localparam logic [4:0] ALUOP_REMU  = 5'b11011;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu(input logic [4:0] op);
    return op[4:2] == 3'b110;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:1] == 4'b1101;
  endfunction

endpackage

// File: rtl/ex_mdu_ctrl_if.sv
// EX <-> MDU request/response bundle.
interface ex_mdu_ctrl_if;
  logic        start_i;
  logic [4:0]  ALUop_i;
  logic [31:0] Oprend1;
  logic [31:0] Oprend2;
  logic [4:0]  WriteDataNum_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] Result_o;
  logic [4:0]  WriteDataNum_o;
  logic        WriteReg_o;

  modport master (
    output start_i, ALUop_i, Oprend1, Oprend2,
    output WriteDataNum_i, flush_i,
    input  stall_o, done_o, Result_o,
    input  WriteDataNum_o, WriteReg_o
  );

  modport slave (
    input  start_i, ALUop_i, Oprend1, Oprend2,
    input  WriteDataNum_i, flush_i,
    output stall_o, done_o, Result_o,
    output WriteDataNum_o, WriteReg_o
  );
endinterface

// File: rtl/ex_mdu_step.sv
// One shift-add multiply / restoring divide iteration.
// Divide path present only with EX_MDU_DIV_EN.
module ex_mdu_step
  import ex_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  input  logic        sbit,
  input  logic [4:0]  op,
  output logic [63:0] acc_nxt
);

  logic [32:0] psum;

  assign psum = {1'b0, acc[63:32]}
              + (sbit ? {1'b0, opnd} : 33'd0);

`ifdef EX_MDU_DIV_EN
  logic [32:0] rsh;
  logic [33:0] trial;

  // Extra sign bit keeps a zero divisor from looking negative.
  assign rsh   = {acc[63:32], sbit};
  assign trial = {1'b0, rsh} - {2'b00, opnd};

  always_comb begin
    acc_nxt = {psum, acc[31:1]};
    if (is_div(op)) begin
      if (!trial[33])
        acc_nxt = {trial[31:0], acc[30:0], 1'b1};
      else
        acc_nxt = {rsh[31:0], acc[30:0], 1'b0};
    end
  end
`else
  always_comb begin
    acc_nxt = {psum, acc[31:1]};
    if (is_div(op))
      acc_nxt = acc;
  end
`endif

endmodule

// File: rtl/ex_mdu_ctrl.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer beside EX.
// EX_MDU_DIV_EN enables the divider; otherwise DIVU/REMU finish at once with 0.
module ex_mdu_ctrl
  import ex_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  ex_mdu_ctrl_if.slave bus
);

  mdu_state_t  state, nxt;
  logic [4:0]  cnt, op, rd_out;
  logic [63:0] acc, acc_nxt;
  logic [31:0] opnd, sreg, res, res_sel;
  logic        done, accept, sbit, req_div;

  assign req_div = is_div(bus.ALUop_i);
  assign accept  = (state == IDLE) && bus.start_i
                && is_mdu(bus.ALUop_i) && !bus.flush_i;

`ifdef EX_MDU_DIV_EN
  assign sbit = is_div(op) ? sreg[31] : sreg[0];
`else
  assign sbit = sreg[0];
`endif

  ex_mdu_step u_step (
    .acc     (acc),
    .opnd    (opnd),
    .sbit    (sbit),
    .op      (op),
    .acc_nxt (acc_nxt)
  );

  // Low half holds product/quotient, high half MULHU/remainder.
  always_comb begin
    res_sel = acc_nxt[31:0];
    if (op[0])
      res_sel = acc_nxt[63:32];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt = BUSY;
`ifndef EX_MDU_DIV_EN
          if (req_div)
            nxt = DONE;
`endif
        end
      end
      BUSY: begin
        if (cnt == 5'(MDU_ITERS - 1))
          nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.flush_i)
      nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      sreg   <= '0;
      op     <= '0;
      rd_out <= '0;
      done   <= 1'b0;
      res    <= '0;
    end else begin
      state  <= nxt;
      done   <= 1'b0;
      res    <= '0;
      rd_out <= '0;
      if (nxt == DONE) begin
        done   <= 1'b1;
        res    <= (state == BUSY) ? res_sel : '0;
        rd_out <= (state == BUSY) ? op_rd() : bus.WriteDataNum_i;
      end
      if (accept) begin
        cnt <= '0;
        acc <= '0;
        op  <= bus.ALUop_i;
`ifdef EX_MDU_DIV_EN
        opnd <= req_div ? bus.Oprend2 : bus.Oprend1;
        sreg <= req_div ? bus.Oprend1 : bus.Oprend2;
`else
        opnd <= bus.Oprend1;
        sreg <= bus.Oprend2;
`endif
      end else if (state == BUSY) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nxt;
`ifdef EX_MDU_DIV_EN
        sreg <= is_div(op) ? (sreg << 1) : (sreg >> 1);
`else
        sreg <= sreg >> 1;
`endif
      end
    end
  end

  logic [4:0] rd_lat;

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_lat <= '0;
    else if (accept)
      rd_lat <= bus.WriteDataNum_i;
  end

  function automatic logic [4:0] op_rd();
    return rd_lat;
  endfunction

  assign bus.stall_o        = accept || (state == BUSY);
  assign bus.done_o         = done;
  assign bus.WriteReg_o     = done;
  assign bus.Result_o       = res;
  assign bus.WriteDataNum_o = rd_out;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Self-checking bench for ex_mdu_ctrl (vector table + scoreboard).
module tb_ex_mdu_ctrl;
  import ex_pkg::*;

`ifdef EX_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mdu_ctrl_if bus ();

  ex_mdu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sb_t  sbq[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      ALUOP_MUL:   return p[31:0];
      ALUOP_MULHU: return p[63:32];
      ALUOP_DIVU:  return !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALUOP_REMU:  return !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
      default:     return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.start_i        = 1'b1;
    bus.ALUop_i        = op;
    bus.Oprend1        = a;
    bus.Oprend2        = b;
    bus.WriteDataNum_i = rd;
  endtask

  task automatic run_op(input vec_t v);
    int  k;
    int  stl;
    int  lat;
    sb_t e;
    lat = (is_div(v.op) && !DIV_EN) ? 0 : 32;
    @(negedge clk);
    drive(v.op, v.a, v.b, v.rd);
    #1 chk("stall_accept", 32'(bus.stall_o), 32'd1);
    sbq.push_back('{v.exp, v.rd});
    @(negedge clk);
    bus.start_i = 1'b0;
    k   = 0;
    stl = 0;
    while (!bus.done_o && k < 40) begin
      if (bus.stall_o) stl++;
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("stall_cycles", 32'(stl), 32'(lat));
    if (bus.done_o) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("result", bus.Result_o, e.res);
        chk("rd_out", 32'(bus.WriteDataNum_o), 32'(e.rd));
        chk("wreg", 32'(bus.WriteReg_o), 32'd1);
        chk("stall_done", 32'(bus.stall_o), 32'd0);
      end
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done_o), 32'd0);
    chk("result_idle", bus.Result_o, 32'd0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_res"}, bus.Result_o, 32'd0);
    chk({tag, "_rd"}, 32'(bus.WriteDataNum_o), 32'd0);
    chk({tag, "_wreg"}, 32'(bus.WriteReg_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   dn;
    vec_t rv;
    logic [4:0] ops[4];

    vecs[0] = '{ALUOP_MUL,   32'd7, 32'd6, 5'd5, 32'd42};
    vecs[1] = '{ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,
                32'hFFFF_FFFE};
    vecs[2] = '{ALUOP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
                32'h0000_0001};
    vecs[3] = '{ALUOP_DIVU,  32'd100, 32'd7, 5'd3,
                DIV_EN ? 32'd14 : 32'd0};
    vecs[4] = '{ALUOP_REMU,  32'd100, 32'd7, 5'd4,
                DIV_EN ? 32'd2 : 32'd0};
    vecs[5] = '{ALUOP_DIVU,  32'd5, 32'd0, 5'd6,
                DIV_EN ? 32'hFFFF_FFFF : 32'd0};
    vecs[6] = '{ALUOP_REMU,  32'd5, 32'd0, 5'd7,
                DIV_EN ? 32'd5 : 32'd0};
    vecs[7] = '{ALUOP_MUL,   32'd7, 32'd6, 5'd31, 32'd42};

    ops[0] = ALUOP_MUL;
    ops[1] = ALUOP_MULHU;
    ops[2] = ALUOP_DIVU;
    ops[3] = ALUOP_REMU;

    rst_n              = 1'b0;
    bus.start_i        = 1'b0;
    bus.flush_i        = 1'b0;
    bus.ALUop_i        = '0;
    bus.Oprend1        = '0;
    bus.Oprend2        = '0;
    bus.WriteDataNum_i = '0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv.op  = ops[i];
      rv.a   = $urandom;
      rv.b   = (i == 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      rv.rd  = 5'(i + 8);
      rv.exp = model(rv.op, rv.a, rv.b);
      run_op(rv);
    end

    // Flush during iteration 10 of a MUL.
    @(negedge clk);
    drive(ALUOP_MUL, 32'd7, 32'd6, 5'd9);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) dn++;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(dn), 32'd0);
    run_op('{ALUOP_DIVU, 32'd9, 32'd3, 5'd10, DIV_EN ? 32'd3 : 32'd0});

    // Reset in the middle of a long operation.
    @(negedge clk);
    drive(DIV_EN ? ALUOP_DIVU : ALUOP_MULHU, 32'd100, 32'd7, 5'd11);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_stall", 32'(bus.stall_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(bus.stall_o), 32'd0);

    // Non-MDU opcode is ignored.
    drive(ALUOP_ADD, 32'd1, 32'd2, 5'd12);
    #1 chk("add_stall", 32'(bus.stall_o), 32'd0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_o || bus.stall_o) dn++;
    end
    bus.start_i = 1'b0;
    chk("add_ignored", 32'(dn), 32'd0);

    // Flush wins over a simultaneous start.
    drive(ALUOP_MUL, 32'd3, 32'd3, 5'd13);
    bus.flush_i = 1'b1;
    #1 chk("fs_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o || bus.stall_o) dn++;
      @(negedge clk);
    end
    chk("fs_ignored", 32'(dn), 32'd0);

    run_op(vecs[0]);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
